sync_coupled_cell: RTL and testbench
====================================

SYNC_COUPLED_CELL -- requirements
Module: sync_coupled_cell

Interface
REQ-001 SHALL have parameter WEIGHT_W, default 3: weight code width.
REQ-002 SHALL have parameter MAX_W, default 2: maximum coupling magnitude; legal range 1..2^(WEIGHT_W-1).
REQ-003 SHALL have parameter NOM_DLY, default 3: nominal path delay in cycles; legal range >= MAX_W+1.
REQ-004 SHALL have parameter TIMEOUT, default 64: maximum cycles a pending weight waits before it is applied.
REQ-005 SHALL have parameter CNT_W, default 16: width of the statistics counter.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 sin  input  1  source oscillator phase.
REQ-009 din  input  1  destination oscillator phase.
REQ-010 sout  output  1  delayed source phase, registered.
REQ-011 dout  output  1  delayed destination phase, registered.
REQ-012 wt_in  input  WEIGHT_W  new weight code.
REQ-013 wt_valid  input  1  wt_in is valid.
REQ-014 wt_ready  output  1  cell can accept a weight.
REQ-015 wt_active  output  WEIGHT_W  weight code currently in effect.

Function
REQ-016 Weight codes SHALL be offset-binary: w = code - MAX_W; any code > 2*MAX_W SHALL be treated as w = 0.
REQ-017 Each path SHALL be a tapped shift register of NOM_DLY+MAX_W stages sampling its input every cycle; output = input sampled d cycles earlier.
REQ-018 Per-cycle mismatch SHALL be computed from registered values only: mis_s = sin_q ^ dout, mis_d = din_q ^ sout (no combinational loop).
REQ-019 Delay SHALL be d = NOM_DLY + w on mismatch, else d = NOM_DLY - w, evaluated independently for each path every cycle.
REQ-020 Weight FSM states SHALL be IDLE and PEND; wt_ready = 1 exactly in IDLE.
REQ-021 In IDLE, wt_valid & wt_ready SHALL capture wt_in into a shadow register and enter PEND.
REQ-022 In PEND, a cycle counter SHALL start at 0; the shadow SHALL be copied to wt_active when both delay lines are quiescent (all stages equal) or the counter reaches TIMEOUT-1, whichever occurs first; the FSM SHALL return to IDLE on the same edge.
REQ-023 wt_valid while in PEND SHALL be ignored (no capture, no error).
REQ-024 A new weight SHALL never alter an output in the same cycle it is captured; it SHALL take effect on the first edge after it is applied.

Reset
REQ-025 While rst_n = 0: delay lines, sout and dout = 0; wt_active = MAX_W (zero coupling); FSM = IDLE; counters = 0.
REQ-026 Reset asserted during PEND SHALL discard the shadow weight.

Configuration
REQ-027 With SYNC_COUPLED_CELL_STATS_EN defined, the cell SHALL add input stat_clr (1) and output mism_cnt (CNT_W); mism_cnt SHALL count cycles with mis_d = 1, saturate at all-ones, and clear synchronously on stat_clr (clear takes priority over increment); reset value 0.
REQ-028 Without SYNC_COUPLED_CELL_STATS_EN, those ports and that logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package sync_coupled_pkg SHALL hold the FSM state enum, default parameter constants, the zero-weight code, and the code-to-delay function.
REQ-030 Sub-module tap_delay_line (parametrised depth, runtime tap select) SHALL be instantiated once per path.

Verification
REQ-031 Reset: assert rst_n = 0 -> sout = dout = 0, wt_active = 3'b010, wt_ready = 1.
REQ-032 Zero weight: din goes 0->1 at cycle 10 -> dout rises at cycle 13. Code 3'b111 -> same 3-cycle delay.
REQ-033 Code 3'b100 (+2): din rises while sout = 0 -> dout follows 5 cycles later; din rises while sout = 1 -> dout follows 1 cycle later.
REQ-034 Code 3'b000 (-2): mismatch -> 1-cycle delay; match -> 5-cycle delay, for both paths.
REQ-035 Weight load: sin toggles every 2 cycles, load 3'b011 -> wt_ready = 0 and wt_active changes exactly 64 cycles after capture. With sin/din held constant, the new weight applies once the lines settle, within NOM_DLY+MAX_W cycles. A second wt_valid during PEND is ignored.
REQ-036 Stats (macro on): 10 mismatch cycles -> mism_cnt = 10. stat_clr asserted with a mismatch in the same cycle -> mism_cnt = 0. Counter forced to all-ones plus one more mismatch -> mism_cnt holds all-ones.

Source files
------------

// File: rtl/sync_coupled_pkg.sv
// Shared types, default parameters and weight-code decoding for sync_coupled_cell.
package sync_coupled_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } wt_state_e;

  localparam int unsigned DEF_WEIGHT_W = 3;
  localparam int unsigned DEF_MAX_W    = 2;
  localparam int unsigned DEF_NOM_DLY  = 3;
  localparam int unsigned DEF_TIMEOUT  = 64;
  localparam int unsigned DEF_CNT_W    = 16;

  localparam logic [DEF_WEIGHT_W-1:0] DEF_ZERO_CODE = DEF_WEIGHT_W'(DEF_MAX_W);

  // Offset-binary code to path delay; out-of-range codes behave as zero coupling.
  function automatic int unsigned code_to_delay(input int unsigned code,
                                                input logic        mis,
                                                input int unsigned max_w,
                                                input int unsigned nom_dly);
    int unsigned dly;
    dly = nom_dly;
    if (code <= 2 * max_w) begin
      if (code > max_w)
        dly = mis ? nom_dly + (code - max_w) : nom_dly - (code - max_w);
      else
        dly = mis ? nom_dly - (max_w - code) : nom_dly + (max_w - code);
    end
    return dly;
  endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Shift register sampling d_in every cycle with a registered, runtime-selected tap.
module tap_delay_line #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic [SEL_W-1:0] sel,
  output logic             q_first,
  output logic             q_out,
  output logic             quiet
);

  logic [DEPTH-1:0] line;
  logic             tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line  <= '0;
      q_out <= 1'b0;
    end else begin
      line  <= {line[DEPTH-2:0], d_in};
      q_out <= tap;
    end
  end

  // line[i] holds the sample taken i+1 edges ago, so sel = delay-1.
  always_comb begin
    tap = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel == SEL_W'(i)) tap = line[i];
    end
  end

  assign q_first = line[0];
  assign quiet   = (line == '0) || (line == '1);

endmodule

// File: rtl/sync_coupled_cell.sv
// Coupled oscillator cell: two weight-modulated delay paths plus a weight-load FSM.
// Optional mismatch statistics enabled by SYNC_COUPLED_CELL_STATS_EN.
module sync_coupled_cell
  import sync_coupled_pkg::*;
#(
  parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
  parameter int unsigned MAX_W    = DEF_MAX_W,
  parameter int unsigned NOM_DLY  = DEF_NOM_DLY,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SYNC_COUPLED_CELL_STATS_EN
  input  logic                stat_clr,
  output logic [CNT_W-1:0]    mism_cnt,
`endif
  input  logic                sin,
  input  logic                din,
  output logic                sout,
  output logic                dout,
  input  logic [WEIGHT_W-1:0] wt_in,
  input  logic                wt_valid,
  output logic                wt_ready,
  output logic [WEIGHT_W-1:0] wt_active
);

  localparam int unsigned DEPTH = NOM_DLY + MAX_W;
  localparam int unsigned SEL_W = $clog2(DEPTH);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [WEIGHT_W-1:0] ZERO_CODE = WEIGHT_W'(MAX_W);

  logic             sin_q, din_q;
  logic             quiet_s, quiet_d;
  logic             mis_s, mis_d;
  logic [SEL_W-1:0] sel_s, sel_d;
  int unsigned      dly_s, dly_d;

  wt_state_e            state, state_nxt;
  logic [WEIGHT_W-1:0]  shadow, shadow_nxt, active_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;

  // Mismatch uses only registered values, so there is no loop through the taps.
  assign mis_s = sin_q ^ dout;
  assign mis_d = din_q ^ sout;

  always_comb begin
    dly_s = code_to_delay(32'(wt_active), mis_s, MAX_W, NOM_DLY);
    dly_d = code_to_delay(32'(wt_active), mis_d, MAX_W, NOM_DLY);
    sel_s = SEL_W'(dly_s - 1);
    sel_d = SEL_W'(dly_d - 1);
  end

  tap_delay_line #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_line_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_in    (sin),
    .sel     (sel_s),
    .q_first (sin_q),
    .q_out   (sout),
    .quiet   (quiet_s)
  );

  tap_delay_line #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_line_d (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_in    (din),
    .sel     (sel_d),
    .q_first (din_q),
    .q_out   (dout),
    .quiet   (quiet_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shadow    <= ZERO_CODE;
      wt_active <= ZERO_CODE;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      wt_active <= active_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    active_nxt  = wt_active;
    tmo_cnt_nxt = tmo_cnt;
    wt_ready    = (state == ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (wt_valid) begin
          shadow_nxt  = wt_in;
          tmo_cnt_nxt = '0;
          state_nxt   = ST_PEND;
        end
      end
      ST_PEND: begin
        if ((quiet_s && quiet_d) || (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
          active_nxt = shadow;
          state_nxt  = ST_IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef SYNC_COUPLED_CELL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mism_cnt <= '0;
    else if (stat_clr)
      mism_cnt <= '0;
    else if (mis_d && (mism_cnt != '1))
      mism_cnt <= mism_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_sync_coupled_cell.sv
// Randomized and directed bench for sync_coupled_cell against a sample-history model.
module tb_sync_coupled_cell;

  localparam int WW    = 3;
  localparam int MAXW  = 2;
  localparam int NOM   = 3;
  localparam int TMO   = 64;
  localparam int CW    = 4;
  localparam int DEPTH = NOM + MAXW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sin = 1'b0, din = 1'b0;
  logic          sout, dout;
  logic [WW-1:0] wt_in = '0;
  logic          wt_valid = 1'b0;
  logic          wt_ready;
  logic [WW-1:0] wt_active;
  logic          stat_clr = 1'b0;
`ifdef SYNC_COUPLED_CELL_STATS_EN
  logic [CW-1:0] mism_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference state: sample histories (index 0 = most recent sample)
  bit hs[DEPTH];
  bit hd[DEPTH];
  bit m_sout, m_dout, m_pend;
  int m_act, m_shadow, m_wait, m_mism;

  sync_coupled_cell #(
    .WEIGHT_W (WW),
    .MAX_W    (MAXW),
    .NOM_DLY  (NOM),
    .TIMEOUT  (TMO),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SYNC_COUPLED_CELL_STATS_EN
    .stat_clr  (stat_clr),
    .mism_cnt  (mism_cnt),
`endif
    .sin       (sin),
    .din       (din),
    .sout      (sout),
    .dout      (dout),
    .wt_in     (wt_in),
    .wt_valid  (wt_valid),
    .wt_ready  (wt_ready),
    .wt_active (wt_active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      hs[i] = 1'b0;
      hd[i] = 1'b0;
    end
    m_sout = 0; m_dout = 0; m_pend = 0;
    m_act = MAXW; m_shadow = MAXW; m_wait = 0; m_mism = 0;
  endtask

  task automatic model_edge();
    int  w, ds, dd;
    bit  ms, md, quiet, ns, nd;
    ms = hs[0] ^ m_dout;
    md = hd[0] ^ m_sout;
    w  = (m_act > 2 * MAXW) ? 0 : m_act - MAXW;
    ds = ms ? NOM + w : NOM - w;
    dd = md ? NOM + w : NOM - w;
    quiet = 1;
    for (int i = 1; i < DEPTH; i++)
      if (hs[i] != hs[0] || hd[i] != hd[0]) quiet = 0;
    if (stat_clr) m_mism = 0;
    else if (md && m_mism != (1 << CW) - 1) m_mism++;
    if (m_pend) begin
      if (quiet || m_wait == TMO - 1) begin
        m_act  = m_shadow;
        m_pend = 0;
      end else begin
        m_wait++;
      end
    end else if (wt_valid) begin
      m_shadow = int'(wt_in);
      m_pend   = 1;
      m_wait   = 0;
    end
    ns = hs[ds-1];
    nd = hd[dd-1];
    for (int i = DEPTH - 1; i > 0; i--) begin
      hs[i] = hs[i-1];
      hd[i] = hd[i-1];
    end
    hs[0] = sin;
    hd[0] = din;
    m_sout = ns;
    m_dout = nd;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_eq("sout", 32'(sout), 32'(m_sout));
    check_eq("dout", 32'(dout), 32'(m_dout));
    check_eq("wt_ready", 32'(wt_ready), 32'(!m_pend));
    check_eq("wt_active", 32'(wt_active), 32'(m_act));
`ifdef SYNC_COUPLED_CELL_STATS_EN
    check_eq("mism_cnt", 32'(mism_cnt), 32'(m_mism));
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int code);
    wt_in    = WW'(code);
    wt_valid = 1'b1;
    step();
    wt_valid = 1'b0;
    steps(3);
  endtask

  // Edges after the sampling edge until the selected output reads 1; -1 if never.
  task automatic measure(input bit use_dout, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if ((use_dout ? dout : sout) == 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_sout", 32'(sout), 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_wt_active", 32'(wt_active), 32'd2);
    check_eq("rst_wt_ready", 32'(wt_ready), 32'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, n, tg;
    model_reset();
    @(negedge clk);
    do_reset();

    // zero weight and out-of-range code: fixed nominal delay
    sin = 0; din = 0; steps(8);
    din = 1; measure(1'b1, lat); check_eq("lat_code2", 32'(lat), 32'd3);
    din = 0; steps(8);
    load(7);
    din = 1; measure(1'b1, lat); check_eq("lat_code7", 32'(lat), 32'd3);
    din = 0; steps(8);

    // +2 coupling
    load(4);
    din = 1; measure(1'b1, lat); check_eq("lat_c4_mis", 32'(lat), 32'd5);
    din = 0; steps(12);
    sin = 1; steps(12);
    din = 1; measure(1'b1, lat); check_eq("lat_c4_match", 32'(lat), 32'd1);
    sin = 0; din = 0; steps(12);

    // -2 coupling, both paths
    load(0);
    din = 1; measure(1'b1, lat); check_eq("lat_c0_d_mis", 32'(lat), 32'd1);
    din = 0; steps(12);
    sin = 1; measure(1'b0, lat); check_eq("lat_c0_s_mis", 32'(lat), 32'd1);
    steps(12);
    din = 1; measure(1'b1, lat); check_eq("lat_c0_d_match", 32'(lat), 32'd5);
    sin = 0; din = 0; steps(12);

    // toggling source never settles: weight applies at the timeout
    tg = 0;
    for (int i = 0; i < 6; i++) begin
      if (tg % 2 == 0) sin = ~sin;
      tg++;
      step();
    end
    wt_in = 3'd3; wt_valid = 1'b1;
    if (tg % 2 == 0) sin = ~sin;
    tg++;
    step();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (tg % 2 == 0) sin = ~sin;
      tg++;
      if (n == 10) begin
        wt_valid = 1'b1; wt_in = 3'd5;
      end else begin
        wt_valid = 1'b0;
      end
      step();
      n++;
      if (n == 30) check_eq("ready_in_pend", 32'(wt_ready), 32'd0);
      if (wt_active == 3'd3) break;
    end
    wt_valid = 1'b0;
    check_eq("timeout_cycles", 32'(n), 32'd64);
    check_eq("ignored_second", 32'(wt_active), 32'd3);
    sin = 0; din = 0; steps(12);

    // constant inputs: applies once lines settle
    sin = 1; wt_in = 3'd6; wt_valid = 1'b1;
    step();
    wt_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (wt_active == 3'd6) break;
    end
    check_eq("settle_apply_le", 32'(n <= NOM + MAXW), 32'd1);
    check_eq("settle_apply_ok", 32'(wt_active), 32'd6);
    sin = 0; steps(12);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 4 == 0) sin = 1'($urandom % 2);
      if ($urandom % 4 == 0) din = 1'($urandom % 2);
      wt_valid = ($urandom % 8 == 0);
      wt_in    = WW'($urandom % 8);
      stat_clr = ($urandom % 50 == 0);
      step();
    end
    wt_valid = 1'b0; stat_clr = 1'b0;

    // reset while pending discards the shadow weight
    sin = 0; din = 0; steps(8);
    tg = 0;
    for (int i = 0; i < 4; i++) begin sin = ~sin; step(); end
    wt_in = 3'd1; wt_valid = 1'b1; sin = ~sin; step();
    wt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin sin = ~sin; step(); end
    check_eq("pend_before_rst", 32'(wt_ready), 32'd0);
    @(negedge clk);
    do_reset();
    sin = 0; din = 0; steps(10);
    check_eq("post_rst_active", 32'(wt_active), 32'd2);

`ifdef SYNC_COUPLED_CELL_STATS_EN
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    din = 1;
    steps(11);
    check_eq("stats_10", 32'(mism_cnt), 32'd10);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check_eq("stats_clr_prio", 32'(mism_cnt), 32'd0);
    steps(20);
    check_eq("stats_sat", 32'(mism_cnt), 32'((1 << CW) - 1));
    din = 0; steps(8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
